// File: rtl/cam_pkg.sv
// Shared definitions for the CAM lookup controller and the CAM instances it drives.
// Holds the default geometry and the controller state encoding.
package cam_pkg;

  localparam int CAM_DEPTH = 16;
  localparam int CAM_INDEX = 4;
  localparam int CAM_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit
// and whether any bit is set at all.
module cam_prio_enc #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4
) (
  input  logic [DEPTH-1:0] vec,
  output logic [INDEX-1:0] index,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last to win
  always_comb begin
    index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      index = vec[i] ? INDEX'(i) : index;
    end
  end

  assign any = |vec;

endmodule

// File: rtl/cam_lookup_ctrl.sv
// Search-side CAM controller: one lookup per request, masked priority match,
// optional insert-on-miss into the lowest free entry or a round-robin victim.
module cam_lookup_ctrl
  import cam_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [CAM_WIDTH-1:0] req_tag_i,
  input  logic                 req_insert_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic                 rsp_multi_o,
  output logic [CAM_INDEX-1:0] rsp_index_o,
  output logic                 rsp_inserted_o,
  input  logic                 flush_i,
  output logic [CAM_WIDTH-1:0] cam_tag_o,
  input  logic [CAM_DEPTH-1:0] cam_match_i,
  output logic                 cam_we_o,
  output logic [CAM_INDEX-1:0] cam_addr_o,
  output logic [CAM_WIDTH-1:0] cam_tagwr_o
);

  cam_state_e           state_r;
  cam_state_e           state_s;
  logic [CAM_WIDTH-1:0] tag_r;
  logic                 ins_r;
  logic [CAM_DEPTH-1:0] valid_r;
  logic [CAM_INDEX-1:0] rr_r;
  logic                 hit_r;
  logic                 multi_r;
  logic [CAM_INDEX-1:0] idx_r;
  logic                 inserted_r;

  logic [CAM_DEPTH-1:0] hv_s;
  logic [CAM_INDEX-1:0] hit_idx_s;
  logic                 hit_s;
  logic [CAM_INDEX-1:0] free_idx_s;
  logic                 free_any_s;
  logic [CAM_INDEX-1:0] victim_s;
  logic                 multi_s;
  logic                 ins_now_s;

  // Stale CAM contents never hit: every match is qualified by valid_r
  assign hv_s      = cam_match_i & valid_r;
  assign multi_s   = |(hv_s & (hv_s - CAM_DEPTH'(1)));
  assign victim_s  = free_any_s ? free_idx_s : rr_r;
  assign ins_now_s = (state_r == ST_LOOKUP) && !hit_s && ins_r && !flush_i;

  cam_prio_enc #(.DEPTH(CAM_DEPTH), .INDEX(CAM_INDEX)) u_hit_enc (
    .vec   (hv_s),
    .index (hit_idx_s),
    .any   (hit_s)
  );

  cam_prio_enc #(.DEPTH(CAM_DEPTH), .INDEX(CAM_INDEX)) u_free_enc (
    .vec   (~valid_r),
    .index (free_idx_s),
    .any   (free_any_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = req_valid_i ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP: state_s = ST_RESP;
      ST_RESP:   state_s = rsp_ready_i ? ST_IDLE : ST_RESP;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Output decode; the CAM write port is live only in the insert cycle
  always_comb begin
    req_ready_o = reset && (state_r == ST_IDLE);
    rsp_valid_o = (state_r == ST_RESP);
    cam_we_o    = ins_now_s;
    cam_addr_o  = ins_now_s ? victim_s : '0;
    cam_tagwr_o = ins_now_s ? tag_r : '0;
  end

  // Request capture, response registers, valid mask and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_r      <= '0;
      ins_r      <= 1'b0;
      valid_r    <= '0;
      rr_r       <= '0;
      hit_r      <= 1'b0;
      multi_r    <= 1'b0;
      idx_r      <= '0;
      inserted_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && req_valid_i) begin
        tag_r <= req_tag_i;
        ins_r <= req_insert_i;
      end
      if (state_r == ST_LOOKUP) begin
        hit_r      <= hit_s && !flush_i;
        multi_r    <= multi_s && !flush_i;
        inserted_r <= ins_now_s;
        if (flush_i) begin
          idx_r <= '0;
        end else if (hit_s) begin
          idx_r <= hit_idx_s;
        end else if (ins_now_s) begin
          idx_r <= victim_s;
        end else begin
          idx_r <= '0;
        end
      end
      if (flush_i) begin
        valid_r <= '0;
      end else if (ins_now_s) begin
        valid_r[victim_s] <= 1'b1;
      end
      // Pointer advances only when a valid entry is evicted
      if (ins_now_s && !free_any_s) begin
        rr_r <= rr_r + CAM_INDEX'(1);
      end
    end
  end

  assign cam_tag_o      = tag_r;
  assign rsp_hit_o      = hit_r;
  assign rsp_multi_o    = multi_r;
  assign rsp_index_o    = idx_r;
  assign rsp_inserted_o = inserted_r;

endmodule
